// File: rtl/ctl_decode_pipe_pkg.sv
// Shared constants for the MIPS main decoder and control pipeline.
// Covers opcode, funct, REGIMM rt and COP0 rs encodings, plus the bundle bit positions.
package ctl_decode_pipe_pkg;

    localparam int CTL_W_MIN = 17;

    typedef logic [CTL_W_MIN-1:0] ctl_bundle_t;

    // Bundle bit positions
    localparam int CTL_JUMP      = 0;
    localparam int CTL_MEMTOREG  = 1;
    localparam int CTL_MEMWRITE  = 2;
    localparam int CTL_BRANCH    = 3;
    localparam int CTL_ALUSRCB   = 4;
    localparam int CTL_REGDST    = 5;
    localparam int CTL_REGWRITE  = 6;
    localparam int CTL_ALUSRCA   = 7;
    localparam int CTL_JAL       = 8;
    localparam int CTL_JR        = 9;
    localparam int CTL_BAL       = 10;
    localparam int CTL_HILOWRITE = 11;
    localparam int CTL_CP0WRITE  = 12;
    localparam int CTL_MEMEN     = 13;
    localparam int CTL_SYSCALL   = 14;
    localparam int CTL_BREAK     = 15;
    localparam int CTL_ERET      = 16;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_COP0   = 6'h10;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SLLV    = 6'h04;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_SRAV    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_BREAK   = 6'h0D;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_ERET    = 6'h18;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    // REGIMM rt field
    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    // COP0 rs field
    localparam logic [4:0] RS_MF = 5'h00;
    localparam logic [4:0] RS_MT = 5'h04;
    localparam logic [4:0] RS_CO = 5'h10;

    function automatic ctl_bundle_t ctl_bit(input int idx);
        ctl_bundle_t b;
        b = '0;
        b[idx] = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/ctl_decode_pipe_stage_reg.sv
// One control pipeline stage register: reset, flush, hold, bubble, load in that priority order.
module ctl_stage_reg #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         hold,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else if (flush) begin
            q_reg <= '0;
        end else if (hold) begin
            q_reg <= q_reg;
        end else if (bubble) begin
            // Upstream is held, so this stage advances with an empty slot.
            q_reg <= '0;
        end else begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/ctl_decode_pipe.sv
// MIPS main decoder producing a fixed control bundle and RI flag, followed by
// NSTAGES registered control stages with per-stage stall and flush.
module ctl_decode_pipe
    import ctl_decode_pipe_pkg::*;
#(
    parameter int CTRL_W  = 17,
    parameter int NSTAGES = 3,
    parameter int IW      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IW-1:0]             instr_d,
    input  logic                      valid_d,
    input  logic [NSTAGES:0]          stall_i,
    input  logic [NSTAGES-1:0]        flush_i,
    output logic [CTRL_W-1:0]         ctrl_d,
    output logic                      ri_d,
    output logic [NSTAGES*CTRL_W-1:0] ctrl_q,
    output logic [NSTAGES-1:0]        valid_q,
    output logic [NSTAGES-1:0]        ri_q
);

    localparam int SW = CTRL_W + 2;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    ctl_bundle_t bundle;
    logic        known;
    logic        unused_bits;

    assign op          = instr_d[31:26];
    assign rs          = instr_d[25:21];
    assign rt          = instr_d[20:16];
    assign funct       = instr_d[5:0];
    assign unused_bits = ^instr_d[15:6];

    always_comb begin
        bundle = '0;
        known  = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA:
                        bundle = ctl_bit(CTL_REGDST) | ctl_bit(CTL_REGWRITE) | ctl_bit(CTL_ALUSRCA);
                    FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR,
                    FN_SLT, FN_SLTU, FN_MFHI, FN_MFLO:
                        bundle = ctl_bit(CTL_REGDST) | ctl_bit(CTL_REGWRITE);
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO:
                        bundle = ctl_bit(CTL_HILOWRITE);
                    FN_JR:
                        bundle = ctl_bit(CTL_JR);
                    // jalr links into rd, so it needs regdst as well as the link path.
                    FN_JALR:
                        bundle = ctl_bit(CTL_JR) | ctl_bit(CTL_JAL)
                               | ctl_bit(CTL_REGDST) | ctl_bit(CTL_REGWRITE);
                    FN_SYSCALL:
                        bundle = ctl_bit(CTL_SYSCALL);
                    FN_BREAK:
                        bundle = ctl_bit(CTL_BREAK);
                    default:
                        known = 1'b0;
                endcase
            end
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ, RT_BGEZ:
                        bundle = ctl_bit(CTL_BRANCH);
                    RT_BLTZAL, RT_BGEZAL:
                        bundle = ctl_bit(CTL_BRANCH) | ctl_bit(CTL_REGWRITE) | ctl_bit(CTL_BAL);
                    default:
                        known = 1'b0;
                endcase
            end
            OP_J:
                bundle = ctl_bit(CTL_JUMP);
            OP_JAL:
                bundle = ctl_bit(CTL_JUMP) | ctl_bit(CTL_JAL) | ctl_bit(CTL_REGWRITE);
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                bundle = ctl_bit(CTL_BRANCH);
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                bundle = ctl_bit(CTL_REGWRITE) | ctl_bit(CTL_ALUSRCB);
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:
                bundle = ctl_bit(CTL_REGWRITE) | ctl_bit(CTL_ALUSRCB)
                       | ctl_bit(CTL_MEMTOREG) | ctl_bit(CTL_MEMEN);
            OP_SB, OP_SH, OP_SW:
                bundle = ctl_bit(CTL_ALUSRCB) | ctl_bit(CTL_MEMWRITE) | ctl_bit(CTL_MEMEN);
            OP_COP0: begin
                case (rs)
                    RS_MF:
                        bundle = ctl_bit(CTL_REGWRITE);
                    RS_MT:
                        bundle = ctl_bit(CTL_CP0WRITE);
                    RS_CO: begin
                        if (funct == FN_ERET) begin
                            bundle = ctl_bit(CTL_ERET);
                        end else begin
                            known = 1'b0;
                        end
                    end
                    default:
                        known = 1'b0;
                endcase
            end
            default:
                known = 1'b0;
        endcase
    end

    // A reserved instruction never carries side-effect bits downstream.
    assign ri_d   = valid_d & ~known;
    assign ctrl_d = (valid_d && known) ? CTRL_W'(bundle) : '0;

    generate
        if (IW > 32) begin : g_wide_instr
            logic unused_high;
            assign unused_high = ^instr_d[IW-1:32];
        end
    endgenerate

    logic [SW-1:0] stage_d [NSTAGES];
    logic [SW-1:0] stage_q [NSTAGES];

    genvar gi;
    generate
        for (gi = 0; gi < NSTAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_d[gi] = {ctrl_d, valid_d, ri_d};
            end else begin : g_next
                assign stage_d[gi] = stage_q[gi-1];
            end

            ctl_stage_reg #(
                .W (SW)
            ) u_stage (
                .clk    (clk),
                .rst    (rst),
                .flush  (flush_i[gi]),
                .hold   (stall_i[gi+1]),
                .bubble (stall_i[gi]),
                .d      (stage_d[gi]),
                .q      (stage_q[gi])
            );

            assign ctrl_q[gi*CTRL_W +: CTRL_W] = stage_q[gi][SW-1:2];
            assign valid_q[gi]                 = stage_q[gi][1];
            assign ri_q[gi]                    = stage_q[gi][0];
        end
    endgenerate

endmodule

// File: tb/tb_ctl_decode_pipe.sv
// Directed bench for ctl_decode_pipe: a 3-stage/17-bit instance with stalls and
// flushes, and a 5-stage/20-bit instance running free on the same instruction stream.
module tb_ctl_decode_pipe;

    localparam logic [31:0] I_LW      = 32'h8D280000;
    localparam logic [31:0] I_SW      = 32'hAD280000;
    localparam logic [31:0] I_ADD     = 32'h00430820;
    localparam logic [31:0] I_RI      = 32'hFC000000;
    localparam logic [31:0] I_ERET    = 32'h42000018;
    localparam logic [31:0] I_SYSCALL = 32'h0000000C;
    localparam logic [31:0] I_BGEZAL  = 32'h04110004;
    localparam logic [31:0] I_J       = 32'h08000000;
    localparam logic [31:0] I_LUI     = 32'h3C010000;
    localparam logic [31:0] I_NOP     = 32'h00000000;
    localparam logic [31:0] I_BADFN   = 32'h00000001;
    localparam logic [31:0] I_BADCP0  = 32'h40200000;
    localparam logic [31:0] I_MFC0    = 32'h40086000;
    localparam logic [31:0] I_MTC0    = 32'h40886000;
    localparam logic [31:0] I_MULT    = 32'h00430018;
    localparam logic [31:0] I_JR      = 32'h03E00008;

    localparam logic [16:0] C_LW      = 17'h02052;
    localparam logic [16:0] C_SW      = 17'h02014;
    localparam logic [16:0] C_ADD     = 17'h00060;
    localparam logic [16:0] C_ERET    = 17'h10000;
    localparam logic [16:0] C_SYSCALL = 17'h04000;
    localparam logic [16:0] C_BGEZAL  = 17'h00448;
    localparam logic [16:0] C_J       = 17'h00001;
    localparam logic [16:0] C_LUI     = 17'h00050;
    localparam logic [16:0] C_NOP     = 17'h000E0;
    localparam logic [16:0] C_MFC0    = 17'h00040;
    localparam logic [16:0] C_MTC0    = 17'h01000;
    localparam logic [16:0] C_MULT    = 17'h00800;
    localparam logic [16:0] C_JR      = 17'h00200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_d = '0;
    logic        valid_d = 1'b0;
    logic [3:0]  stall_i = '0;
    logic [2:0]  flush_i = '0;
    logic [16:0] ctrl_d;
    logic        ri_d;
    logic [50:0] ctrl_q;
    logic [2:0]  valid_q;
    logic [2:0]  ri_q;

    logic [5:0]  stall5 = '0;
    logic [4:0]  flush5 = '0;
    logic [19:0] ctrl_d5;
    logic        ri_d5;
    logic [99:0] ctrl_q5;
    logic [4:0]  valid_q5;
    logic [4:0]  ri_q5;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [16:0] c;
        logic        v;
        logic        r;
    } ent_t;

    typedef struct packed {
        ent_t [4:0] s;
    } snap_t;

    snap_t m3 = '0;
    snap_t m5 = '0;
    snap_t q3[$];
    snap_t q5[$];

    always #5 clk = ~clk;

    ctl_decode_pipe #(.CTRL_W(17), .NSTAGES(3), .IW(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .instr_d (instr_d),
        .valid_d (valid_d),
        .stall_i (stall_i),
        .flush_i (flush_i),
        .ctrl_d  (ctrl_d),
        .ri_d    (ri_d),
        .ctrl_q  (ctrl_q),
        .valid_q (valid_q),
        .ri_q    (ri_q)
    );

    ctl_decode_pipe #(.CTRL_W(20), .NSTAGES(5), .IW(32)) dut5 (
        .clk     (clk),
        .rst     (rst),
        .instr_d (instr_d),
        .valid_d (valid_d),
        .stall_i (stall5),
        .flush_i (flush5),
        .ctrl_d  (ctrl_d5),
        .ri_d    (ri_d5),
        .ctrl_q  (ctrl_q5),
        .valid_q (valid_q5),
        .ri_q    (ri_q5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: drive inputs, check the decoder, predict every stage, clock, compare.
    task automatic step(input logic r, input logic [31:0] ins, input logic v,
                        input logic [3:0] st, input logic [2:0] fl,
                        input logic [16:0] ec, input logic er);
        ent_t  up;
        snap_t n3;
        snap_t n5;
        snap_t e3;
        snap_t e5;
        rst     = r;
        instr_d = ins;
        valid_d = v;
        stall_i = st;
        flush_i = fl;
        #1;
        chk("ctrl_d", 32'(ctrl_d), 32'(ec));
        chk("ri_d", 32'(ri_d), 32'(er));
        chk("ctrl_d_w20", 32'(ctrl_d5), 32'(ec));
        chk("ri_d_w20", 32'(ri_d5), 32'(er));

        up.c = ec;
        up.v = v;
        up.r = er;
        n3 = '0;
        for (int k = 0; k < 3; k++) begin
            if (r || fl[k])       n3.s[k] = '0;
            else if (st[k+1])     n3.s[k] = m3.s[k];
            else if (st[k])       n3.s[k] = '0;
            else if (k == 0)      n3.s[k] = up;
            else                  n3.s[k] = m3.s[k-1];
        end
        n5 = '0;
        for (int k = 0; k < 5; k++) begin
            if (r)                n5.s[k] = '0;
            else if (k == 0)      n5.s[k] = up;
            else                  n5.s[k] = m5.s[k-1];
        end
        m3 = n3;
        m5 = n5;
        q3.push_back(n3);
        q5.push_back(n5);

        @(posedge clk);
        #1;
        e3 = q3.pop_front();
        e5 = q5.pop_front();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("n3_s%0d_ctrl", k), 32'(ctrl_q[k*17 +: 17]), 32'(e3.s[k].c));
            chk($sformatf("n3_s%0d_valid", k), 32'(valid_q[k]), 32'(e3.s[k].v));
            chk($sformatf("n3_s%0d_ri", k), 32'(ri_q[k]), 32'(e3.s[k].r));
        end
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("n5_s%0d_ctrl", k), 32'(ctrl_q5[k*20 +: 20]), 32'(e5.s[k].c));
            chk($sformatf("n5_s%0d_valid", k), 32'(valid_q5[k]), 32'(e5.s[k].v));
            chk($sformatf("n5_s%0d_ri", k), 32'(ri_q5[k]), 32'(e5.s[k].r));
        end
        $display("step ins=%h v=%0d st=%b fl=%b rst=%0d -> ctrl_d=%h ri_d=%0d valid_q=%b ri_q=%b",
                 ins, v, st, fl, r, ctrl_d, ri_d, valid_q, ri_q);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, I_NOP, 1'b0, 4'b0000, 3'b000, 17'h0, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, with a valid instruction presented: stages must stay empty.
        step(1'b1, I_LW, 1'b1, 4'b0000, 3'b000, C_LW, 1'b0);
        step(1'b1, I_NOP, 1'b0, 4'b0000, 3'b000, 17'h0, 1'b0);

        // lw flows through both pipes; reaches stage4 of the 5-stage pipe at +5.
        step(1'b0, I_LW, 1'b1, 4'b0000, 3'b000, C_LW, 1'b0);
        idle(5);

        // Reserved instruction travels with valid=1, ri=1, ctrl=0.
        step(1'b0, I_RI, 1'b1, 4'b0000, 3'b000, 17'h0, 1'b1);
        idle(3);

        // Stage0 holds syscall for two cycles while stage1 takes bubbles.
        step(1'b0, I_SYSCALL, 1'b1, 4'b0000, 3'b000, C_SYSCALL, 1'b0);
        step(1'b0, I_ADD, 1'b1, 4'b0011, 3'b000, C_ADD, 1'b0);
        step(1'b0, I_ADD, 1'b1, 4'b0011, 3'b000, C_ADD, 1'b0);
        step(1'b0, I_ADD, 1'b1, 4'b0000, 3'b000, C_ADD, 1'b0);
        idle(3);

        // Flush beats hold on stage0.
        step(1'b0, I_ERET, 1'b1, 4'b0000, 3'b000, C_ERET, 1'b0);
        step(1'b0, I_BGEZAL, 1'b1, 4'b0010, 3'b001, C_BGEZAL, 1'b0);
        step(1'b0, I_BGEZAL, 1'b1, 4'b0000, 3'b000, C_BGEZAL, 1'b0);

        // Decoder coverage across classes, including the reserved cases.
        step(1'b0, I_SW, 1'b1, 4'b0000, 3'b000, C_SW, 1'b0);
        step(1'b0, I_J, 1'b1, 4'b0000, 3'b000, C_J, 1'b0);
        step(1'b0, I_LUI, 1'b1, 4'b0000, 3'b000, C_LUI, 1'b0);
        step(1'b0, I_BADFN, 1'b1, 4'b0000, 3'b000, 17'h0, 1'b1);
        step(1'b0, I_BADCP0, 1'b1, 4'b0000, 3'b000, 17'h0, 1'b1);
        step(1'b0, I_RI, 1'b0, 4'b0000, 3'b000, 17'h0, 1'b0);
        step(1'b0, I_NOP, 1'b1, 4'b0000, 3'b000, C_NOP, 1'b0);
        step(1'b0, I_MFC0, 1'b1, 4'b0000, 3'b000, C_MFC0, 1'b0);
        step(1'b0, I_MTC0, 1'b1, 4'b0000, 3'b000, C_MTC0, 1'b0);
        step(1'b0, I_MULT, 1'b1, 4'b0000, 3'b000, C_MULT, 1'b0);
        step(1'b0, I_JR, 1'b1, 4'b0000, 3'b000, C_JR, 1'b0);

        // Deeper stalls and flushes.
        step(1'b0, I_LW, 1'b1, 4'b1000, 3'b000, C_LW, 1'b0);
        step(1'b0, I_ADD, 1'b1, 4'b0100, 3'b000, C_ADD, 1'b0);
        step(1'b0, I_SYSCALL, 1'b1, 4'b0000, 3'b110, C_SYSCALL, 1'b0);
        step(1'b0, I_ERET, 1'b1, 4'b0000, 3'b000, C_ERET, 1'b0);

        // Fill every stage, then a single reset cycle clears all of them.
        step(1'b0, I_LW, 1'b1, 4'b0000, 3'b000, C_LW, 1'b0);
        step(1'b0, I_SW, 1'b1, 4'b0000, 3'b000, C_SW, 1'b0);
        step(1'b0, I_ADD, 1'b1, 4'b0000, 3'b000, C_ADD, 1'b0);
        step(1'b1, I_LW, 1'b1, 4'b0000, 3'b000, C_LW, 1'b0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
